change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vend_pkg.sv | 20 ++
 rtl/change_coin_select.sv | 25 ++
 rtl/change_dispenser.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared state encoding, coin encodings and coin values for the change dispenser.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EJECT  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] COIN_NONE    = 2'd0;
    localparam logic [1:0] COIN_NICKEL  = 2'd1;
    localparam logic [1:0] COIN_DIME    = 2'd2;
    localparam logic [1:0] COIN_QUARTER = 2'd3;

    localparam logic [7:0] VAL_NICKEL  = 8'd5;
    localparam logic [7:0] VAL_DIME    = 8'd10;
    localparam logic [7:0] VAL_QUARTER = 8'd25;

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin choice: the largest coin that still fits in the remaining amount.
module change_coin_select
    import vend_pkg::*;
(
    input  logic [7:0] remaining,
    output logic [1:0] coin_type,
    output logic [7:0] coin_value
);

    always_comb begin
        coin_type  = COIN_NONE;
        coin_value = 8'd0;
        if (remaining >= VAL_QUARTER) begin
            coin_type  = COIN_QUARTER;
            coin_value = VAL_QUARTER;
        end else if (remaining >= VAL_DIME) begin
            coin_type  = COIN_DIME;
            coin_value = VAL_DIME;
        end else if (remaining >= VAL_NICKEL) begin
            coin_type  = COIN_NICKEL;
            coin_value = VAL_NICKEL;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: presents coins one at a time until less than a nickel remains.
// Optional coin_ack timeout is enabled with `define CHANGE_TIMEOUT_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       coin_ack,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    output logic       busy,
    output logic       done,
    output logic [7:0] residual,
    output logic       err
);

    state_e     state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic       coin_valid_q, coin_valid_d;
    logic [1:0] coin_type_q, coin_type_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] residual_q, residual_d;
    logic       ack_taken;
    logic [1:0] sel_type;
    logic [7:0] sel_value;

`ifdef CHANGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    change_coin_select u_select (
        .remaining  (remaining_q),
        .coin_type  (sel_type),
        .coin_value (sel_value)
    );

    // An ack only counts once the coin is actually visible on coin_valid.
    assign ack_taken = (state_q == ST_EJECT) && coin_valid_q && coin_ack;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
`ifdef CHANGE_TIMEOUT_EN
        cnt_d       = cnt_q;
        abort_d     = abort_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    state_d     = ST_SELECT;
`ifdef CHANGE_TIMEOUT_EN
                    abort_d     = 1'b0;
`endif
                end
            end
            ST_SELECT: begin
                state_d = (sel_type == COIN_NONE) ? ST_DONE : ST_EJECT;
`ifdef CHANGE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_EJECT: begin
                if (ack_taken) begin
                    remaining_d = remaining_q - sel_value;
                    state_d     = ST_SELECT;
                end
`ifdef CHANGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    abort_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so the coin shows one cycle after EJECT is entered.
        coin_valid_d = (state_q == ST_EJECT) && (state_d == ST_EJECT);
        coin_type_d  = coin_valid_d ? sel_type : COIN_NONE;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_q == ST_DONE);
        residual_d   = done_d ? remaining_q : 8'd0;
`ifdef CHANGE_TIMEOUT_EN
        err_d        = done_d && abort_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= 8'd0;
            coin_valid_q <= 1'b0;
            coin_type_q  <= COIN_NONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            residual_q   <= 8'd0;
`ifdef CHANGE_TIMEOUT_EN
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_valid_q <= coin_valid_d;
            coin_type_q  <= coin_type_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            residual_q   <= residual_d;
`ifdef CHANGE_TIMEOUT_EN
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            err_q        <= err_d;
`endif
        end
    end

    assign coin_valid = coin_valid_q;
    assign coin_type  = coin_type_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign residual   = residual_q;
`ifdef CHANGE_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule
